// File: rtl/sggoc_pkg.sv
// Shared constants and types for the cartridge slot mapper.
package sggoc_pkg;

    // CPU address map boundaries of the cartridge window
    localparam logic [15:0] SLOT_FIXED_END = 16'h0400;
    localparam logic [15:0] SLOT1_BASE     = 16'h4000;
    localparam logic [15:0] SLOT2_BASE     = 16'h8000;
    localparam logic [15:0] RAM_BASE       = 16'hC000;

    // Paging register addresses
    localparam logic [15:0] REG_CTRL  = 16'hFFFC;
    localparam logic [15:0] REG_BANK0 = 16'hFFFD;
    localparam logic [15:0] REG_BANK1 = 16'hFFFE;
    localparam logic [15:0] REG_BANK2 = 16'hFFFF;

    // Power-on bank selections: identity mapping of the first 48 KB
    localparam logic [7:0] BANK0_RST = 8'd0;
    localparam logic [7:0] BANK1_RST = 8'd1;
    localparam logic [7:0] BANK2_RST = 8'd2;

    // Flash read sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } fl_state_t;

endpackage

// File: rtl/cart_mapper_if.sv
// Z80 memory bus as seen by the cartridge slot.
// The Z80 "do" data-out signal is named dout because do is a keyword.
interface cart_mapper_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] addr;
    logic [7:0]  di;
    logic [7:0]  dout;
    logic        wait_n;

    modport master (
        output mem_rd, mem_wr, addr, di,
        input  dout, wait_n
    );

    modport slave (
        input  mem_rd, mem_wr, addr, di,
        output dout, wait_n
    );
endinterface

// File: rtl/cart_mapper_reader.sv
// Flash read sequencer: holds CE/OE low for FL_WAIT cycles, captures the
// byte and stretches the Z80 cycle with wait_n until the byte is valid.
module flash_reader
    import sggoc_pkg::*;
#(
    parameter int FL_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        hold,
    input  logic [21:0] req_addr,
    input  logic [7:0]  fl_dq,
    output logic [7:0]  data,
    output logic        wait_n,
    output logic [21:0] fl_addr,
    output logic        fl_ce_n,
    output logic        fl_oe_n
);

    localparam int CW = $clog2(FL_WAIT + 1);

    fl_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic        en_n, en_n_next;
    logic [7:0]  data_next;
    logic [21:0] addr_next;

    // State register plus the flash address, strobe, counter and data latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            en_n    <= 1'b1;
            data    <= 8'hFF;
            fl_addr <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            en_n    <= en_n_next;
            data    <= data_next;
            fl_addr <= addr_next;
        end
    end

    // Next-state logic; an access that loses mem_rd is dropped without touching data
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        en_n_next  = en_n;
        data_next  = data;
        addr_next  = fl_addr;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_next = ST_ACCESS;
                    addr_next  = req_addr;
                    en_n_next  = 1'b0;
                    cnt_next   = CW'(FL_WAIT - 1);
                end
            end
            ST_ACCESS: begin
                if (!hold) begin
                    state_next = ST_IDLE;
                    en_n_next  = 1'b1;
                end else if (cnt == '0) begin
                    data_next  = fl_dq;
                    en_n_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_DONE: begin
                if (!hold) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign fl_ce_n = en_n;
    assign fl_oe_n = en_n;

    // Combinational so the CPU is stalled in the very cycle mem_rd rises;
    // reset releases the CPU immediately even if mem_rd is still high.
    assign wait_n = ~(reset_n & req & (state != ST_DONE));

endmodule

// File: rtl/cart_mapper.sv
// Sega-style cartridge mapper: paging registers at 0xFFFC-0xFFFF and the
// translation of Z80 reads in 0x0000-0xBFFF into 22-bit flash addresses.
module cart_mapper
    import sggoc_pkg::*;
#(
    parameter int         FL_WAIT   = 4,
    parameter logic [7:0] BANK_MASK = 8'hFF
) (
    input  logic          clk,
    input  logic          reset_n,
    cart_mapper_if.slave  bus,
    input  logic [7:0]    fl_dq,
    output logic [21:0]   fl_addr,
    output logic          fl_ce_n,
    output logic          fl_oe_n,
    output logic          fl_we_n,
    output logic          fl_rst_n
);

    logic        mem_wr_d;
    logic        reg_wr;
    logic [7:0]  ctrl;
    logic [7:0]  bank0, bank1, bank2;
    logic [7:0]  bank_sel;
    logic [21:0] xlat_addr;
    logic        cart_sel;

    // A write counts once, on the rising edge of mem_wr, and only in the register window
    assign reg_wr = bus.mem_wr & ~mem_wr_d & (bus.addr >= REG_CTRL);

    // Paging registers, write-edge detector and flash reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_wr_d <= 1'b0;
            ctrl     <= 8'h00;
            bank0    <= BANK0_RST;
            bank1    <= BANK1_RST;
            bank2    <= BANK2_RST;
            fl_rst_n <= 1'b0;
        end else begin
            mem_wr_d <= bus.mem_wr;
            fl_rst_n <= 1'b1;
            if (reg_wr) begin
                case (bus.addr[1:0])
                    REG_CTRL[1:0]:  ctrl  <= bus.di;
                    REG_BANK0[1:0]: bank0 <= bus.di;
                    REG_BANK1[1:0]: bank1 <= bus.di;
                    default:        bank2 <= bus.di;
                endcase
            end
        end
    end

    // Slot decode; the first 1 KB always maps to bank 0 so the reset vectors survive paging
    always_comb begin
        bank_sel = 8'h00;
        if (bus.addr < SLOT_FIXED_END)  bank_sel = 8'h00;
        else if (bus.addr < SLOT1_BASE) bank_sel = bank0 & BANK_MASK;
        else if (bus.addr < SLOT2_BASE) bank_sel = bank1 & BANK_MASK;
        else                            bank_sel = bank2 & BANK_MASK;
        xlat_addr = {bank_sel, bus.addr[13:0]};
    end

    // Simultaneous read and write is treated as a write; RAM owns 0xC000 upward
    assign cart_sel = bus.mem_rd & ~bus.mem_wr & (bus.addr < RAM_BASE);
    assign fl_we_n  = 1'b1;

    flash_reader #(.FL_WAIT(FL_WAIT)) u_reader (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (cart_sel),
        .hold     (bus.mem_rd),
        .req_addr (xlat_addr),
        .fl_dq    (fl_dq),
        .data     (bus.dout),
        .wait_n   (bus.wait_n),
        .fl_addr  (fl_addr),
        .fl_ce_n  (fl_ce_n),
        .fl_oe_n  (fl_oe_n)
    );

endmodule
